match_scheduler: RTL and testbench
==================================

# match_scheduler

Sequencing controller for the gate-level price comparator (`matching_engine`). It accepts buy and sell orders over valid/ready handshakes and holds one resting order per side. It presents the resting pair to the comparator, samples the match result, and emits trades over a valid/ready output. It sits between the order generator and the downstream trade logger, and is the only driver of the comparator's price inputs.

## Interface
- `QTY_W`, 8, quantity width in bits
- `CNT_W`, 16, trade counter width in bits
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: synchronous, active-low reset
- `buy_valid` in 1 / `buy_ready` out 1: buy order handshake
- `buy_price` in 8 / `buy_qty` in QTY_W: buy order fields
- `sell_valid` in 1 / `sell_ready` out 1: sell order handshake
- `sell_price` in 8 / `sell_qty` in QTY_W: sell order fields
- `flush` in 1: clears both resting slots
- `eng_buy_price` out 8 / `eng_sell_price` out 8: comparator inputs
- `eng_match_flag` in 1 / `eng_spread` in 8: comparator outputs (combinational, same cycle)
- `trade_valid` out 1 / `trade_ready` in 1: trade output handshake
- `trade_price` out 8 / `trade_qty` out QTY_W / `trade_spread` out 8: trade fields
- `buy_resting` out 1 / `sell_resting` out 1: slot occupancy
- `trade_count` out CNT_W: completed trades, wraps modulo 2^CNT_W

## Operation
- Each side has one slot holding a price, a remaining quantity and a full bit.
- `eng_buy_price` and `eng_sell_price` are driven directly from the slot registers. An empty slot drives 0.
- State machine IDLE → EVAL → TRADE → IDLE.
- **IDLE**
  - `buy_ready = !buy_resting || stale`; `sell_ready` is symmetric.
  - Buy and sell handshakes may both fire in the same cycle.
  - A fire into a full slot replaces the resting order; the old order is discarded.
  - An order with qty 0 is accepted but not loaded. It does not clear `stale`.
  - Any loading fire clears `stale`.
  - Go to EVAL when both slots are full after this edge and `stale` is 0 after this edge.
- **EVAL** (exactly 1 cycle; both ready signals are 0)
  - If `eng_match_flag=1`: latch `trade_price` = resting sell price, `trade_qty` = min(buy qty, sell qty), `trade_spread` = `eng_spread`. Go to TRADE.
  - Else: set `stale=1` and go to IDLE. The pair stays resting until either side is replaced.
- **TRADE** (both ready signals are 0)
  - `trade_valid=1`; trade fields are held stable until the handshake.
  - On `trade_ready`:
    - subtract `trade_qty` from both remaining quantities;
    - clear the full bit of any slot whose remaining quantity reaches 0;
    - increment `trade_count`;
    - go to IDLE.
  - At least one slot always empties. Both empty on equal quantities.
- **flush**
  - Has priority over everything else.
  - Forces both ready signals to 0 that cycle, clears the full bits and `stale`, and deasserts `trade_valid` (the pending trade is abandoned and not counted). Go to IDLE.
  - `trade_count` is kept.
- **Reset values:** state IDLE; slots empty; `stale=0`; `trade_valid=0`; trade fields 0; `trade_count=0`; `eng_*` outputs 0. Both ready signals are 1 during the first cycle after reset release.
- Reset asserted mid-trade has the same effect as flush, and in addition zeroes `trade_count`.

## Timing
- Cycle N: the handshake that fills the second slot. Cycle N+1: EVAL. Cycle N+2: `trade_valid`=1.
- Minimum trade latency is therefore 2 cycles.
- Occupancy outputs update the cycle after the handshake. They are registered, not combinational from valid.
- `trade_ready` held high: TRADE lasts 1 cycle, and the next order is accepted at N+3.
- The comparator path is combinational from registers to `eng_match_flag`. It must close within one period in EVAL.
- Ready signals are functions of registered state only; no valid→ready combinational path.
- `trade_count` increments on the edge ending the trade handshake cycle.

## Test plan
- Equal quantities: buy 100/qty 5 at cycle 0, sell 90/qty 5 at cycle 1.
  - Required: `trade_valid` at cycle 3 with price 90, qty 5, spread 10.
  - After the handshake both slots are empty and `trade_count`=1.
- Simultaneous partial fill: buy 50/qty 8 and sell 50/qty 3 in the same cycle 0.
  - Required: trade at cycle 2 with price 50, qty 3, spread 0.
  - Afterwards the buy stays resting with qty 5 and the sell slot is empty.
- No match then replace: buy 40/qty 2, sell 60/qty 2.
  - Required: EVAL finds no match, no trade, both ready signals reassert.
  - New sell 35/qty 2: trade at price 35, qty 2, spread 5.
- Backpressure: hold `trade_ready`=0 for 10 cycles during a trade.
  - Required: `trade_valid` and the fields stay stable, both ready signals stay 0, and `trade_count` is unchanged until release.
- Flush mid-trade: assert `flush` while `trade_valid`=1.
  - Required: the next cycle `trade_valid`=0, both occupancy outputs 0, `trade_count` unchanged.
- Zero quantity and wrap: a buy with qty 0 is accepted and the slot stays empty.
  - Preload `trade_count` to 0xFFFF via 65535 trades (or force); the next trade gives 0x0000.

Source files
------------

// File: rtl/match_scheduler_if.sv
// Order and trade handshakes for match_scheduler. The master side is the order generator and
// trade logger; the slave side is the scheduler.
interface match_scheduler_if #(
  parameter int unsigned QTY_W = 8
) ();
  logic             buy_valid;
  logic             buy_ready;
  logic [7:0]       buy_price;
  logic [QTY_W-1:0] buy_qty;
  logic             sell_valid;
  logic             sell_ready;
  logic [7:0]       sell_price;
  logic [QTY_W-1:0] sell_qty;
  logic             trade_valid;
  logic             trade_ready;
  logic [7:0]       trade_price;
  logic [QTY_W-1:0] trade_qty;
  logic [7:0]       trade_spread;

  modport master (
    output buy_valid, buy_price, buy_qty,
    input  buy_ready,
    output sell_valid, sell_price, sell_qty,
    input  sell_ready,
    input  trade_valid, trade_price, trade_qty, trade_spread,
    output trade_ready
  );

  modport slave (
    input  buy_valid, buy_price, buy_qty,
    output buy_ready,
    input  sell_valid, sell_price, sell_qty,
    output sell_ready,
    output trade_valid, trade_price, trade_qty, trade_spread,
    input  trade_ready
  );
endinterface

// File: rtl/match_scheduler.sv
// Holds one resting buy and one resting sell, presents them to the external price comparator,
// and turns a reported match into a single trade on the output handshake.
module match_scheduler #(
  parameter int unsigned QTY_W = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  match_scheduler_if.slave     bus,
  input  logic                 flush,
  output logic [7:0]           eng_buy_price,
  output logic [7:0]           eng_sell_price,
  input  logic                 eng_match_flag,
  input  logic [7:0]           eng_spread,
  output logic                 buy_resting,
  output logic                 sell_resting,
  output logic [CNT_W-1:0]     trade_count
);

  typedef enum logic [1:0] {StIdle, StEval, StTrade} state_e;

  state_e           state_q, state_d;
  logic [7:0]       buy_price_q, buy_price_d, sell_price_q, sell_price_d;
  logic [QTY_W-1:0] buy_qty_q, buy_qty_d, sell_qty_q, sell_qty_d;
  logic             buy_full_q, buy_full_d, sell_full_q, sell_full_d;
  logic             stale_q, stale_d;
  logic [7:0]       trade_price_q, trade_price_d, trade_spread_q, trade_spread_d;
  logic [QTY_W-1:0] trade_qty_q, trade_qty_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             buy_load, sell_load, trade_fire;
  logic [QTY_W-1:0] min_qty;

  // Zero-quantity orders complete the handshake but never occupy a slot.
  assign buy_load   = bus.buy_valid && bus.buy_ready && (bus.buy_qty != '0);
  assign sell_load  = bus.sell_valid && bus.sell_ready && (bus.sell_qty != '0);
  assign trade_fire = bus.trade_valid && bus.trade_ready;
  assign min_qty    = (buy_qty_q < sell_qty_q) ? buy_qty_q : sell_qty_q;

  assign eng_buy_price    = buy_full_q ? buy_price_q : 8'd0;
  assign eng_sell_price   = sell_full_q ? sell_price_q : 8'd0;
  assign buy_resting      = buy_full_q;
  assign sell_resting     = sell_full_q;
  assign trade_count      = count_q;
  assign bus.trade_price  = trade_price_q;
  assign bus.trade_qty    = trade_qty_q;
  assign bus.trade_spread = trade_spread_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (buy_full_d && sell_full_d && !stale_d) state_d = StEval;
      StEval:  state_d = eng_match_flag ? StTrade : StIdle;
      StTrade: if (trade_fire) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (flush) state_d = StIdle;
  end

  // Flush masks every handshake in its cycle so a pending trade cannot complete.
  always_comb begin
    bus.buy_ready   = 1'b0;
    bus.sell_ready  = 1'b0;
    bus.trade_valid = 1'b0;
    if (!flush) begin
      case (state_q)
        StIdle: begin
          bus.buy_ready  = !buy_full_q || stale_q;
          bus.sell_ready = !sell_full_q || stale_q;
        end
        StTrade: bus.trade_valid = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    buy_price_d    = buy_price_q;
    buy_qty_d      = buy_qty_q;
    buy_full_d     = buy_full_q;
    sell_price_d   = sell_price_q;
    sell_qty_d     = sell_qty_q;
    sell_full_d    = sell_full_q;
    stale_d        = stale_q;
    trade_price_d  = trade_price_q;
    trade_qty_d    = trade_qty_q;
    trade_spread_d = trade_spread_q;
    count_d        = count_q;
    if (flush) begin
      buy_full_d  = 1'b0;
      sell_full_d = 1'b0;
      stale_d     = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (buy_load) begin
            buy_price_d = bus.buy_price;
            buy_qty_d   = bus.buy_qty;
            buy_full_d  = 1'b1;
            stale_d     = 1'b0;
          end
          if (sell_load) begin
            sell_price_d = bus.sell_price;
            sell_qty_d   = bus.sell_qty;
            sell_full_d  = 1'b1;
            stale_d      = 1'b0;
          end
        end
        StEval: begin
          if (eng_match_flag) begin
            trade_price_d  = sell_price_q;
            trade_qty_d    = min_qty;
            trade_spread_d = eng_spread;
          end else begin
            stale_d = 1'b1;
          end
        end
        StTrade: begin
          if (trade_fire) begin
            buy_qty_d  = buy_qty_q - trade_qty_q;
            sell_qty_d = sell_qty_q - trade_qty_q;
            if (buy_qty_d == '0) buy_full_d = 1'b0;
            if (sell_qty_d == '0) sell_full_d = 1'b0;
            count_d = count_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buy_price_q    <= '0;
      buy_qty_q      <= '0;
      buy_full_q     <= 1'b0;
      sell_price_q   <= '0;
      sell_qty_q     <= '0;
      sell_full_q    <= 1'b0;
      stale_q        <= 1'b0;
      trade_price_q  <= '0;
      trade_qty_q    <= '0;
      trade_spread_q <= '0;
      count_q        <= '0;
    end else begin
      buy_price_q    <= buy_price_d;
      buy_qty_q      <= buy_qty_d;
      buy_full_q     <= buy_full_d;
      sell_price_q   <= sell_price_d;
      sell_qty_q     <= sell_qty_d;
      sell_full_q    <= sell_full_d;
      stale_q        <= stale_d;
      trade_price_q  <= trade_price_d;
      trade_qty_q    <= trade_qty_d;
      trade_spread_q <= trade_spread_d;
      count_q        <= count_d;
    end
  end

endmodule

// File: tb/tb_match_scheduler.sv
// Scenario bench for match_scheduler: a comparator model, a queue of expected trades filled when
// orders are driven, and per-scenario tasks that compare DUT outputs against that queue.
module tb_match_scheduler;
  localparam int unsigned QtyW = 8;
  localparam int unsigned CntW = 16;

  typedef struct packed {
    logic [7:0]      price;
    logic [QtyW-1:0] qty;
    logic [7:0]      spread;
  } trade_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic [7:0]      eng_buy_price, eng_sell_price, eng_spread;
  logic            eng_match_flag;
  logic            buy_resting, sell_resting;
  logic [CntW-1:0] trade_count;

  int              errors = 0;
  int              checks = 0;
  trade_t          exp_q[$];
  trade_t          exp_t;
  logic [CntW-1:0] exp_count = '0;
  bit              ok;
  int              cyc;

  match_scheduler_if #(.QTY_W(QtyW)) bus ();

  match_scheduler #(.QTY_W(QtyW), .CNT_W(CntW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .flush          (flush),
    .eng_buy_price  (eng_buy_price),
    .eng_sell_price (eng_sell_price),
    .eng_match_flag (eng_match_flag),
    .eng_spread     (eng_spread),
    .buy_resting    (buy_resting),
    .sell_resting   (sell_resting),
    .trade_count    (trade_count)
  );

  // Comparator model: a buy crosses when it bids at or above the ask.
  assign eng_match_flag = (eng_buy_price >= eng_sell_price);
  assign eng_spread     = eng_buy_price - eng_sell_price;

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic trade_t model_trade(input logic [7:0] bp, input logic [QtyW-1:0] bq,
                                         input logic [7:0] sp, input logic [QtyW-1:0] sq);
    trade_t t;
    t.price  = sp;
    t.qty    = (bq < sq) ? bq : sq;
    t.spread = bp - sp;
    return t;
  endfunction

  task automatic drive_orders(input logic bv, input logic [7:0] bp, input logic [QtyW-1:0] bq,
                              input logic sv, input logic [7:0] sp, input logic [QtyW-1:0] sq);
    bus.buy_valid  = bv;
    bus.buy_price  = bp;
    bus.buy_qty    = bq;
    bus.sell_valid = sv;
    bus.sell_price = sp;
    bus.sell_qty   = sq;
    @(posedge clk);
    #1;
    bus.buy_valid  = 1'b0;
    bus.sell_valid = 1'b0;
  endtask

  // Waits for trade_valid; cyc counts negedges after the cycle following the last order edge.
  task automatic wait_trade(input int max_cyc, output bit found, output int n);
    found = 1'b0;
    n     = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (bus.trade_valid) begin
        found = 1'b1;
        n     = i;
        return;
      end
    end
  endtask

  task automatic accept_trade();
    bus.trade_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.trade_ready = 1'b0;
  endtask

  task automatic pulse_flush();
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.buy_ready, bus.sell_ready} !== 2'b11) begin
      errors++;
      $display("FAIL reset_ready: got %b want 11", {bus.buy_ready, bus.sell_ready});
    end
    checks++;
    if ({bus.trade_valid, buy_resting, sell_resting} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 000", {bus.trade_valid, buy_resting, sell_resting});
    end
    checks++;
    if (trade_count !== '0) begin
      errors++;
      $display("FAIL reset_count: got %0h want 0", trade_count);
    end
    checks++;
    if ({eng_buy_price, eng_sell_price} !== 16'h0) begin
      errors++;
      $display("FAIL reset_eng: got %h want 0000", {eng_buy_price, eng_sell_price});
    end
    checks++;
    if ({bus.trade_price, bus.trade_qty, bus.trade_spread} !== 24'h0) begin
      errors++;
      $display("FAIL reset_fields: got %h want 000000",
               {bus.trade_price, bus.trade_qty, bus.trade_spread});
    end
  endtask

  task automatic test_equal_qty();
    drive_orders(1'b1, 8'd100, 8'd5, 1'b0, 8'd0, 8'd0);
    @(negedge clk);
    checks++;
    if ({buy_resting, bus.buy_ready, bus.sell_ready, eng_buy_price} !== {3'b101, 8'd100}) begin
      errors++;
      $display("FAIL eq_buy_rest: got %b/%0d want 101/100",
               {buy_resting, bus.buy_ready, bus.sell_ready}, eng_buy_price);
    end
    exp_q.push_back(model_trade(8'd100, 8'd5, 8'd90, 8'd5));
    drive_orders(1'b0, 8'd0, 8'd0, 1'b1, 8'd90, 8'd5);
    wait_trade(20, ok, cyc);
    checks++;
    if (!ok || cyc != 1) begin
      errors++;
      $display("FAIL eq_latency: got found=%0d cyc=%0d want found=1 cyc=1", ok, cyc);
    end
    if (ok) begin
      exp_t = exp_q.pop_front();
      checks++;
      if ({bus.trade_price, bus.trade_qty, bus.trade_spread} !== exp_t) begin
        errors++;
        $display("FAIL eq_fields: got %h want %h",
                 {bus.trade_price, bus.trade_qty, bus.trade_spread}, exp_t);
      end
      accept_trade();
      exp_count++;
    end
    @(negedge clk);
    checks++;
    if ({buy_resting, sell_resting} !== 2'b00 || trade_count !== exp_count) begin
      errors++;
      $display("FAIL eq_after: got rest=%b cnt=%0d want rest=00 cnt=%0d",
               {buy_resting, sell_resting}, trade_count, exp_count);
    end
  endtask

  task automatic test_partial();
    exp_q.push_back(model_trade(8'd50, 8'd8, 8'd50, 8'd3));
    drive_orders(1'b1, 8'd50, 8'd8, 1'b1, 8'd50, 8'd3);
    wait_trade(20, ok, cyc);
    checks++;
    if (!ok || cyc != 1) begin
      errors++;
      $display("FAIL part_latency: got found=%0d cyc=%0d want found=1 cyc=1", ok, cyc);
    end
    if (ok) begin
      exp_t = exp_q.pop_front();
      checks++;
      if ({bus.trade_price, bus.trade_qty, bus.trade_spread} !== exp_t) begin
        errors++;
        $display("FAIL part_fields: got %h want %h",
                 {bus.trade_price, bus.trade_qty, bus.trade_spread}, exp_t);
      end
      accept_trade();
      exp_count++;
    end
    @(negedge clk);
    checks++;
    if ({buy_resting, sell_resting} !== 2'b10 || eng_buy_price !== 8'd50) begin
      errors++;
      $display("FAIL part_rest: got rest=%b price=%0d want rest=10 price=50",
               {buy_resting, sell_resting}, eng_buy_price);
    end
    // The leftover buy qty (5) shows up as the size of the next fill.
    exp_q.push_back(model_trade(8'd50, 8'd5, 8'd45, 8'd9));
    drive_orders(1'b0, 8'd0, 8'd0, 1'b1, 8'd45, 8'd9);
    wait_trade(20, ok, cyc);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL part_second: got found=0 want found=1");
    end else begin
      exp_t = exp_q.pop_front();
      checks++;
      if ({bus.trade_price, bus.trade_qty, bus.trade_spread} !== exp_t) begin
        errors++;
        $display("FAIL part_remainder: got %h want %h",
                 {bus.trade_price, bus.trade_qty, bus.trade_spread}, exp_t);
      end
      accept_trade();
      exp_count++;
    end
    @(negedge clk);
    checks++;
    if ({buy_resting, sell_resting} !== 2'b01 || trade_count !== exp_count) begin
      errors++;
      $display("FAIL part_after: got rest=%b cnt=%0d want rest=01 cnt=%0d",
               {buy_resting, sell_resting}, trade_count, exp_count);
    end
    pulse_flush();
  endtask

  task automatic test_no_match();
    drive_orders(1'b1, 8'd40, 8'd2, 1'b1, 8'd60, 8'd2);
    @(negedge clk);
    checks++;
    if ({bus.buy_ready, bus.sell_ready, bus.trade_valid} !== 3'b000) begin
      errors++;
      $display("FAIL nm_eval: got %b want 000", {bus.buy_ready, bus.sell_ready, bus.trade_valid});
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.buy_ready, bus.sell_ready, bus.trade_valid, buy_resting, sell_resting} !== 5'b11011)
    begin
      errors++;
      $display("FAIL nm_stale: got %b want 11011",
               {bus.buy_ready, bus.sell_ready, bus.trade_valid, buy_resting, sell_resting});
    end
    exp_q.push_back(model_trade(8'd40, 8'd2, 8'd35, 8'd2));
    drive_orders(1'b0, 8'd0, 8'd0, 1'b1, 8'd35, 8'd2);
    wait_trade(20, ok, cyc);
    checks++;
    if (!ok || cyc != 1) begin
      errors++;
      $display("FAIL nm_latency: got found=%0d cyc=%0d want found=1 cyc=1", ok, cyc);
    end
    if (ok) begin
      exp_t = exp_q.pop_front();
      checks++;
      if ({bus.trade_price, bus.trade_qty, bus.trade_spread} !== exp_t) begin
        errors++;
        $display("FAIL nm_fields: got %h want %h",
                 {bus.trade_price, bus.trade_qty, bus.trade_spread}, exp_t);
      end
      accept_trade();
      exp_count++;
    end
    @(negedge clk);
    checks++;
    if (trade_count !== exp_count || {buy_resting, sell_resting} !== 2'b00) begin
      errors++;
      $display("FAIL nm_after: got cnt=%0d rest=%b want cnt=%0d rest=00",
               trade_count, {buy_resting, sell_resting}, exp_count);
    end
  endtask

  task automatic test_backpressure();
    exp_q.push_back(model_trade(8'd70, 8'd4, 8'd65, 8'd6));
    drive_orders(1'b1, 8'd70, 8'd4, 1'b1, 8'd65, 8'd6);
    wait_trade(20, ok, cyc);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bp_start: got found=0 want found=1");
    end else begin
      exp_t = exp_q.pop_front();
      for (int i = 0; i < 10; i++) begin
        checks++;
        if (!bus.trade_valid || {bus.trade_price, bus.trade_qty, bus.trade_spread} !== exp_t ||
            bus.buy_ready || bus.sell_ready || trade_count !== exp_count) begin
          errors++;
          $display("FAIL bp_hold[%0d]: got v=%b f=%h rdy=%b cnt=%0d want v=1 f=%h rdy=00 cnt=%0d",
                   i, bus.trade_valid, {bus.trade_price, bus.trade_qty, bus.trade_spread},
                   {bus.buy_ready, bus.sell_ready}, trade_count, exp_t, exp_count);
        end
        @(negedge clk);
      end
      accept_trade();
      exp_count++;
    end
    @(negedge clk);
    checks++;
    if (trade_count !== exp_count || {buy_resting, sell_resting} !== 2'b01) begin
      errors++;
      $display("FAIL bp_after: got cnt=%0d rest=%b want cnt=%0d rest=01",
               trade_count, {buy_resting, sell_resting}, exp_count);
    end
  endtask

  task automatic test_flush();
    // Sell 65 with 2 remaining is still resting from the backpressure scenario.
    exp_q.push_back(model_trade(8'd80, 8'd1, 8'd65, 8'd2));
    drive_orders(1'b1, 8'd80, 8'd1, 1'b0, 8'd0, 8'd0);
    wait_trade(20, ok, cyc);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL fl_start: got found=0 want found=1");
    end else begin
      exp_t = exp_q.pop_front();
      checks++;
      if ({bus.trade_price, bus.trade_qty, bus.trade_spread} !== exp_t) begin
        errors++;
        $display("FAIL fl_fields: got %h want %h",
                 {bus.trade_price, bus.trade_qty, bus.trade_spread}, exp_t);
      end
    end
    flush = 1'b1;
    bus.trade_ready = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    bus.trade_ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.trade_valid, buy_resting, sell_resting} !== 3'b000 || trade_count !== exp_count) begin
      errors++;
      $display("FAIL fl_after: got v/rest=%b cnt=%0d want 000 cnt=%0d",
               {bus.trade_valid, buy_resting, sell_resting}, trade_count, exp_count);
    end
    checks++;
    if ({bus.buy_ready, bus.sell_ready} !== 2'b11 || {eng_buy_price, eng_sell_price} !== 16'h0)
    begin
      errors++;
      $display("FAIL fl_idle: got rdy=%b eng=%h want rdy=11 eng=0000",
               {bus.buy_ready, bus.sell_ready}, {eng_buy_price, eng_sell_price});
    end
    flush = 1'b1;
    #1;
    checks++;
    if ({bus.buy_ready, bus.sell_ready} !== 2'b00) begin
      errors++;
      $display("FAIL fl_ready_mask: got %b want 00", {bus.buy_ready, bus.sell_ready});
    end
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic test_back_to_back();
    bus.trade_ready = 1'b1;
    exp_q.push_back(model_trade(8'd20, 8'd1, 8'd20, 8'd1));
    drive_orders(1'b1, 8'd20, 8'd1, 1'b1, 8'd20, 8'd1);
    @(negedge clk);
    checks++;
    if ({bus.trade_valid, bus.buy_ready, bus.sell_ready} !== 3'b000) begin
      errors++;
      $display("FAIL b2b_eval: got %b want 000", {bus.trade_valid, bus.buy_ready, bus.sell_ready});
    end
    @(negedge clk);
    exp_t = exp_q.pop_front();
    checks++;
    if (!bus.trade_valid || {bus.trade_price, bus.trade_qty, bus.trade_spread} !== exp_t) begin
      errors++;
      $display("FAIL b2b_trade: got v=%b f=%h want v=1 f=%h", bus.trade_valid,
               {bus.trade_price, bus.trade_qty, bus.trade_spread}, exp_t);
    end
    exp_count++;
    @(negedge clk);
    checks++;
    if ({bus.buy_ready, bus.sell_ready, bus.trade_valid} !== 3'b110 || trade_count !== exp_count)
    begin
      errors++;
      $display("FAIL b2b_next: got %b cnt=%0d want 110 cnt=%0d",
               {bus.buy_ready, bus.sell_ready, bus.trade_valid}, trade_count, exp_count);
    end
    bus.trade_ready = 1'b0;
  endtask

  task automatic test_zero_qty_wrap();
    drive_orders(1'b1, 8'd55, 8'd0, 1'b0, 8'd0, 8'd0);
    @(negedge clk);
    checks++;
    if (buy_resting !== 1'b0 || bus.buy_ready !== 1'b1) begin
      errors++;
      $display("FAIL zq_empty: got rest=%b rdy=%b want rest=0 rdy=1", buy_resting, bus.buy_ready);
    end
    // A zero-qty replacement of a stale pair must not trigger a re-evaluation.
    drive_orders(1'b1, 8'd40, 8'd2, 1'b1, 8'd60, 8'd2);
    repeat (3) @(negedge clk);
    drive_orders(1'b1, 8'd99, 8'd0, 1'b0, 8'd0, 8'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (bus.trade_valid || !buy_resting || eng_buy_price !== 8'd40) begin
        errors++;
        $display("FAIL zq_stale[%0d]: got v=%b rest=%b price=%0d want v=0 rest=1 price=40",
                 i, bus.trade_valid, buy_resting, eng_buy_price);
      end
    end
    pulse_flush();
    @(negedge clk);
    force dut.count_q = 16'hFFFF;
    @(negedge clk);
    release dut.count_q;
    exp_count = 16'hFFFF;
    checks++;
    if (trade_count !== exp_count) begin
      errors++;
      $display("FAIL wrap_preload: got %0h want ffff", trade_count);
    end
    exp_q.push_back(model_trade(8'd30, 8'd1, 8'd30, 8'd1));
    drive_orders(1'b1, 8'd30, 8'd1, 1'b1, 8'd30, 8'd1);
    wait_trade(20, ok, cyc);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wrap_trade: got found=0 want found=1");
    end else begin
      exp_t = exp_q.pop_front();
      accept_trade();
      exp_count++;
    end
    @(negedge clk);
    checks++;
    if (trade_count !== exp_count || exp_count !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_count: got %0h want 0", trade_count);
    end
  endtask

  initial begin
    bus.buy_valid   = 1'b0;
    bus.buy_price   = '0;
    bus.buy_qty     = '0;
    bus.sell_valid  = 1'b0;
    bus.sell_price  = '0;
    bus.sell_qty    = '0;
    bus.trade_ready = 1'b0;
    test_reset();
    test_equal_qty();
    test_partial();
    test_no_match();
    test_backpressure();
    test_flush();
    test_back_to_back();
    test_zero_qty_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
